regfile_alu_sequencer: RTL and testbench

// Multi-cycle controller owning both ports of the 64x16 register file.

---
 rtl/regfile_alu_sequencer_if.sv | 33 +++
 rtl/regfile_alu_sequencer.sv | 129 ++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_alu_sequencer_if.sv
// Instruction handshake plus register-file bus for regfile_alu_sequencer.
// The master side is the sequencer (it masters the register file); the slave side
// is the surrounding logic: instruction source and register file.
interface regfile_alu_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  InstrValid;
    logic                  InstrReady;
    logic [1:0]            Opcode;
    logic [ADDR_WIDTH-1:0] DestAddr;
    logic [ADDR_WIDTH-1:0] SrcAddr;
    logic [ADDR_WIDTH-1:0] RF_AddressA;
    logic [ADDR_WIDTH-1:0] RF_AddressB;
    logic [DATA_WIDTH-1:0] RF_WriteData;
    logic                  RF_WriteEnable;
    logic [DATA_WIDTH-1:0] RF_ReadDataA;
    logic [DATA_WIDTH-1:0] RF_ReadDataB;
    logic                  Done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        input  InstrValid, Opcode, DestAddr, SrcAddr, RF_ReadDataA, RF_ReadDataB,
        output InstrReady, RF_AddressA, RF_AddressB, RF_WriteData, RF_WriteEnable,
               Done, Result
    );

    modport slave (
        output InstrValid, Opcode, DestAddr, SrcAddr, RF_ReadDataA, RF_ReadDataB,
        input  InstrReady, RF_AddressA, RF_AddressB, RF_WriteData, RF_WriteEnable,
               Done, Result
    );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// Multi-cycle sequencer owning both register-file ports. Executes one
// Dest <= Dest op Src instruction (ADD/SUB/MUL/MOV) per handshake:
// IDLE -> READ -> EXEC (1 cycle, or DATA_WIDTH cycles of shift-add for MUL) -> WRITE.
module regfile_alu_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input logic                     Clock,
    input logic                     nReset,
    regfile_alu_sequencer_if.master bus
);
    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpMov = 2'b11;

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CntW-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_accept;
    logic                  w_mul_last;

    assign w_accept   = (r_state == StIdle) && bus.InstrValid;
    assign w_mul_last = (r_cnt == CntLast);
    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign w_acc_next = r_opb[0] ? (r_acc + r_opa) : r_acc;

    // Single-cycle ALU result; for MUL this is the final accumulation step.
    always_comb begin
        w_alu = '0;
        unique case (r_op)
            OpAdd: w_alu = r_opa + r_opb;
            OpSub: w_alu = r_opa - r_opb;
            OpMul: w_alu = w_acc_next;
            OpMov: w_alu = r_opb;
        endcase
    end

    // State register; async reset aborts any instruction in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.InstrValid) w_state_next = StRead;
            StRead:  w_state_next = StExec;
            StExec:  if (r_op != OpMul || w_mul_last) w_state_next = StWrite;
            StWrite: w_state_next = StIdle;
        endcase
    end

    // Datapath: latch instruction, capture operands, iterate MUL, hold result.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_op     <= OpAdd;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op     <= bus.Opcode;
                        r_addr_a <= bus.DestAddr;
                        r_addr_b <= bus.SrcAddr;
                    end
                end
                StRead: begin
                    r_opa <= bus.RF_ReadDataA;
                    r_opb <= bus.RF_ReadDataB;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                StExec: begin
                    if (r_op == OpMul) begin
                        r_acc <= w_acc_next;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                        r_cnt <= r_cnt + CntW'(1);
                        if (w_mul_last) r_wdata <= w_alu;
                    end else begin
                        r_wdata <= w_alu;
                    end
                end
                StWrite: begin
                    r_result <= r_wdata;
                end
            endcase
        end
    end

    // Outputs decoded from state so reset drops WriteEnable/Done immediately.
    always_comb begin
        bus.InstrReady     = (r_state == StIdle);
        bus.RF_WriteEnable = (r_state == StWrite);
        bus.Done           = (r_state == StWrite);
        bus.RF_AddressA    = r_addr_a;
        bus.RF_AddressB    = r_addr_b;
        bus.RF_WriteData   = r_wdata;
        bus.Result         = r_result;
    end
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Self-checking bench: behavioural 64x16 register file, golden register model and a
// scoreboard of expected write-backs popped on every Done.
module tb_regfile_alu_sequencer;
    localparam int DW = 16;
    localparam int AW = 6;

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    always #5 Clock = ~Clock;

    regfile_alu_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_alu_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] val;
        int            acc_cyc;
        int            lat;
    } exp_t;

    logic [DW-1:0] rf   [64];
    logic [DW-1:0] gold [64];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    exp_t          q [$];
    int            tests_run = 0;
    int            fails = 0;
    int            cyc = 0;
    int            we_count = 0;

    assign bus.RF_ReadDataA = rf[bus.RF_AddressA];
    assign bus.RF_ReadDataB = rf[bus.RF_AddressB];

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (bus.RF_WriteEnable) rf[bus.RF_AddressA] <= bus.RF_WriteData;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    // Scoreboard: every Done must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (nReset) begin
            if (bus.RF_WriteEnable) we_count++;
            if (bus.Done) begin
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_done: Done with no outstanding instruction");
                end else begin
                    e = q.pop_front();
                    gold[e.dest] = e.val;
                    if (bus.RF_AddressA !== e.dest || bus.RF_WriteData !== e.val ||
                        bus.RF_WriteEnable !== 1'b1 || (cyc - e.acc_cyc + 1) != e.lat) begin
                        fails++;
                        $display("FAIL sb_writeback: got addr=%0d data=%h we=%b lat=%0d, want addr=%0d data=%h we=1 lat=%0d",
                                 bus.RF_AddressA, bus.RF_WriteData, bus.RF_WriteEnable,
                                 cyc - e.acc_cyc + 1, e.dest, e.val, e.lat);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge Clock);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = v;
        gold[a] = v;
        @(negedge Clock);
        pre_we = 1'b0;
    endtask

    // Drives an instruction and holds InstrValid until accepted; returns after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] d, input logic [AW-1:0] s,
                         output int waited);
        exp_t e;
        logic [DW-1:0] a, b;
        @(negedge Clock);
        bus.InstrValid = 1'b1;
        bus.Opcode = op;
        bus.DestAddr = d;
        bus.SrcAddr = s;
        waited = 0;
        while (bus.InstrReady !== 1'b1 && waited < 100) begin
            @(negedge Clock);
            waited++;
        end
        if (bus.InstrReady !== 1'b1) begin
            tests_run++;
            fails++;
            $display("FAIL issue_timeout: InstrReady=%b after %0d cycles, want 1", bus.InstrReady, waited);
            bus.InstrValid = 1'b0;
            return;
        end
        a = gold[d];
        b = gold[s];
        case (op)
            2'b00: e.val = a + b;
            2'b01: e.val = a - b;
            2'b10: e.val = a * b;
            default: e.val = b;
        endcase
        e.dest = d;
        e.acc_cyc = cyc + 1;
        e.lat = (op == 2'b10) ? DW + 2 : 3;
        q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        tests_run++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL done_timeout: %0d write-backs outstanding, want 0", q.size());
            q.delete();
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        bus.InstrValid = 1'b0;
        bus.Opcode = 2'b00;
        bus.DestAddr = '0;
        bus.SrcAddr = '0;
        #1;
        tests_run++;
        if (bus.RF_WriteEnable !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 16'h0) begin
            fails++;
            $display("FAIL reset_hold: we=%b done=%b result=%h, want 0 0 0000",
                     bus.RF_WriteEnable, bus.Done, bus.Result);
        end
        repeat (3) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        tests_run++;
        if (bus.InstrReady !== 1'b1 || bus.RF_WriteData !== 16'h0 ||
            bus.RF_AddressA !== 6'd0 || bus.RF_AddressB !== 6'd0) begin
            fails++;
            $display("FAIL reset_release: ready=%b wdata=%h addrA=%0d addrB=%0d, want 1 0000 0 0",
                     bus.InstrReady, bus.RF_WriteData, bus.RF_AddressA, bus.RF_AddressB);
        end
    endtask

    task automatic test_add();
        int w;
        preload(6'd1, 16'd5);
        preload(6'd2, 16'd7);
        issue(2'b00, 6'd1, 6'd2, w);
        bus.InstrValid = 1'b0;
        wait_done();
        tests_run++;
        if (rf[1] !== 16'd12 || bus.Result !== 16'd12) begin
            fails++;
            $display("FAIL add: R1=%h Result=%h, want 000c 000c", rf[1], bus.Result);
        end
    endtask

    task automatic test_sub_wrap();
        int w, wc;
        preload(6'd3, 16'h0003);
        preload(6'd4, 16'h0005);
        wc = we_count;
        issue(2'b01, 6'd3, 6'd4, w);
        bus.InstrValid = 1'b0;
        wait_done();
        tests_run++;
        if (rf[3] !== 16'hFFFE || bus.Result !== 16'hFFFE || we_count - wc != 1) begin
            fails++;
            $display("FAIL sub_wrap: R3=%h Result=%h we_pulses=%0d, want fffe fffe 1",
                     rf[3], bus.Result, we_count - wc);
        end
    endtask

    task automatic test_mul();
        int w;
        preload(6'd5, 16'h0123);
        preload(6'd6, 16'h0100);
        issue(2'b10, 6'd5, 6'd6, w);
        bus.InstrValid = 1'b0;
        wait_done();
        tests_run++;
        if (rf[5] !== 16'h2300 || bus.Result !== 16'h2300) begin
            fails++;
            $display("FAIL mul: R5=%h Result=%h, want 2300 2300", rf[5], bus.Result);
        end
    endtask

    task automatic test_mul_square_held_valid();
        int w;
        preload(6'd7, 16'hFFFF);
        issue(2'b10, 6'd7, 6'd7, w);
        // Held request: MOV R12 <= R7 must wait the whole MUL and see its write.
        issue(2'b11, 6'd12, 6'd7, w);
        bus.InstrValid = 1'b0;
        tests_run++;
        if (w != DW + 2) begin
            fails++;
            $display("FAIL busy_cycles: InstrReady low for %0d cycles, want %0d", w, DW + 2);
        end
        wait_done();
        tests_run++;
        if (rf[7] !== 16'h0001 || rf[12] !== 16'h0001) begin
            fails++;
            $display("FAIL mul_square: R7=%h R12=%h, want 0001 0001", rf[7], rf[12]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        preload(6'd8, 16'hBEEF);
        issue(2'b11, 6'd9, 6'd8, w);
        issue(2'b00, 6'd9, 6'd9, w);
        bus.InstrValid = 1'b0;
        wait_done();
        tests_run++;
        if (rf[9] !== 16'h7DDE || bus.Result !== 16'h7DDE) begin
            fails++;
            $display("FAIL back_to_back: R9=%h Result=%h, want 7dde 7dde", rf[9], bus.Result);
        end
    endtask

    task automatic test_reset_abort();
        int w, wc;
        preload(6'd10, 16'h1234);
        preload(6'd11, 16'h0003);
        issue(2'b10, 6'd10, 6'd11, w);
        bus.InstrValid = 1'b0;
        repeat (5) @(posedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        q.delete();
        wc = we_count;
        tests_run++;
        if (bus.RF_WriteEnable !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 16'h0) begin
            fails++;
            $display("FAIL abort_async: we=%b done=%b result=%h, want 0 0 0000",
                     bus.RF_WriteEnable, bus.Done, bus.Result);
        end
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        tests_run++;
        if (bus.InstrReady !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready: InstrReady=%b after release, want 1", bus.InstrReady);
        end
        repeat (25) @(negedge Clock);
        tests_run++;
        if (we_count != wc || rf[10] !== 16'h1234 || bus.Result !== 16'h0) begin
            fails++;
            $display("FAIL abort_nowrite: we_pulses=%0d R10=%h Result=%h, want 0 1234 0000",
                     we_count - wc, rf[10], bus.Result);
        end
        issue(2'b00, 6'd10, 6'd11, w);
        bus.InstrValid = 1'b0;
        wait_done();
        tests_run++;
        if (rf[10] !== 16'h1237 || bus.Result !== 16'h1237) begin
            fails++;
            $display("FAIL after_abort: R10=%h Result=%h, want 1237 1237", rf[10], bus.Result);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) gold[i] = '0;
        test_reset();
        test_add();
        test_sub_wrap();
        test_mul();
        test_mul_square_held_valid();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
